instruction_fetch: RTL



---
 rtl/cpu_pkg.sv | 19 +
 rtl/instruction_fetch_if.sv | 12 +
 rtl/instruction_fetch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encodings, the NOP encoding and the instruction width.
package cpu_pkg;

    localparam logic [1:0] REQ     = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;
    localparam logic [1:0] FAULT   = 2'd3;

    typedef enum logic [1:0] {
        S_REQ     = REQ,
        S_HOLD    = HOLD,
        S_DISCARD = DISCARD,
        S_FAULT   = FAULT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface instruction_fetch_if;
    // o_mem_req rises with o_mem_addr and both stay constant until the single-cycle
    // i_mem_ack; i_mem_rdata is meaningful only in that ack cycle.
    logic [31:0] o_mem_addr;
    logic        o_mem_req;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;

    modport master (output o_mem_addr, output o_mem_req, input i_mem_rdata, input i_mem_ack);
    modport slave  (input o_mem_addr, input o_mem_req, output i_mem_rdata, output i_mem_ack);
endinterface

// File: rtl/instruction_fetch.sv
// Multicycle fetch stage: PC, instruction register and memory read FSM.
// Optional macro FETCH_ALIGN_CHECK_EN adds o_fetch_fault and the FAULT state.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    instruction_fetch_if.master        mem,
    input  logic                       i_next,
    input  logic                       i_redirect,
    input  logic [31:0]                i_redirect_pc,
    output logic [31:0]                o_IR,
    output logic [31:0]                o_PC,
    output logic                       o_valid,
    output logic                       o_busy,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic                       o_fetch_fault,
`endif
    output logic [1:0]                 o_dbg_state
);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_mem_addr;
    logic         r_mem_req;
    logic [31:0]  r_ir;
    logic [31:0]  r_pc;
    logic         r_valid;
    logic         r_fault;
    logic [31:0]  w_target;
    logic         w_bad_target;

    assign w_target = i_redirect_pc & ~(32'(INSTR_BYTES) - 32'd1);

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_bad_target  = (i_redirect_pc[1:0] != 2'b00);
    assign o_fetch_fault = r_fault;
`else
    assign w_bad_target  = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_ir       <= NOP_INSTR;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    // With no read in flight, acks are stray and are ignored.
                    if (!r_mem_req) begin
                        if (i_redirect) begin
                            if (w_bad_target) begin
                                r_fault <= 1'b1;
                                r_state <= S_FAULT;
                            end else begin
                                r_fetch_pc <= w_target;
                            end
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_fetch_pc;
                        end
                    end else if (i_redirect) begin
                        r_fault <= w_bad_target;
                        if (!w_bad_target) r_fetch_pc <= w_target;
                        if (mem.i_mem_ack) begin
                            r_mem_req <= 1'b0;
                            r_state   <= w_bad_target ? S_FAULT : S_REQ;
                        end else begin
                            r_state <= S_DISCARD;
                        end
                    end else if (mem.i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_ir      <= mem.i_mem_rdata;
                        r_pc      <= r_fetch_pc;
                        r_valid   <= 1'b1;
                        r_state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_redirect) begin
                        r_valid <= 1'b0;
                        r_fault <= w_bad_target;
                        if (!w_bad_target) r_fetch_pc <= w_target;
                        r_state <= w_bad_target ? S_FAULT : S_REQ;
                    end else if (i_next) begin
                        r_valid    <= 1'b0;
                        r_fetch_pc <= r_pc + PC_STEP;
                        r_state    <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    // The stale read must complete; the last redirect seen decides where to go next.
                    if (i_redirect) begin
                        r_fault <= w_bad_target;
                        if (!w_bad_target) r_fetch_pc <= w_target;
                    end
                    if (mem.i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= (i_redirect ? w_bad_target : r_fault) ? S_FAULT : S_REQ;
                    end
                end
                S_FAULT: begin
                    if (i_redirect && !w_bad_target) begin
                        r_fault    <= 1'b0;
                        r_fetch_pc <= w_target;
                        r_state    <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    assign mem.o_mem_addr = r_mem_addr;
    assign mem.o_mem_req  = r_mem_req;
    assign o_IR           = r_ir;
    assign o_PC           = r_pc;
    assign o_valid        = r_valid;
    assign o_busy         = (r_state == S_REQ) || (r_state == S_DISCARD);
    assign o_dbg_state    = r_state;

endmodule
